// File: rtl/bus_sync_tx.sv
// bus_sync_tx: source side of a toggle-handshake multi-bit bus crossing.
// A word accepted on in_valid/in_ready is registered onto xfer_data and
// announced by flipping xfer_req. No new word is taken until the echoed
// xfer_ack, resynchronised through NUMSTGS flops, matches xfer_req again.
//
// Handshake: a word moves on every rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on registers, never on
// in_valid, and xfer_data only changes on such an accept edge.
//
// Optional feature: define BUS_SYNC_TX_TIMEOUT_EN to build the ack timeout
// counter and the sticky timeout_err flag. Without it timeout_err is 0.
module bus_sync_tx #(
    parameter int DATAWTH  = 8,
    parameter int NUMSTGS  = 2,
    parameter int TOCYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATAWTH-1:0] in_data,
    output logic [DATAWTH-1:0] xfer_data,
    output logic               xfer_req,
    input  logic               xfer_ack,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [NUMSTGS-1:0] sync_q, sync_d;
    logic               ack_sync;
    logic [0:0]         state_q, state_d;
    logic               req_q, req_d;
    logic [DATAWTH-1:0] data_q, data_d;
    logic               accept;
    logic               ack_match;

    // Only the last synchronizer stage is ever looked at.
    assign ack_sync  = sync_q[NUMSTGS-1];
    assign ack_match = (ack_sync == req_q);

    // A stale ack left over from an un-reset destination holds in_ready low.
    assign in_ready  = (state_q == ST_IDLE) && ack_match;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == ST_WAIT);
    assign xfer_data = data_q;
    assign xfer_req  = req_q;

    // Next-state logic: accept in IDLE, wait for the matching ack in WAIT.
    always_comb begin
        sync_d  = {sync_q[NUMSTGS-2:0], xfer_ack};
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    req_d   = ~req_q;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                if (ack_match) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State, request toggle, held data and the ack synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

`ifdef BUS_SYNC_TX_TIMEOUT_EN
    localparam int             CNTW    = $clog2(TOCYCLES + 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TOCYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TOCYCLES - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            terr_q, terr_d;

    // Counts edges since accept; the TOCYCLES-th edge still in WAIT flags.
    // The transfer itself is never aborted, only reported.
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
                terr_d = 1'b1;
            end
        end
    end

    // Timeout counter and sticky error flag; only rst clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sync_tx.sv
// Directed bench for bus_sync_tx (NUMSTGS=2, TOCYCLES=8). The timeout
// section follows BUS_SYNC_TX_TIMEOUT_EN the same way the design does.
module tb_bus_sync_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] xfer_data;
    logic          xfer_req;
    logic          xfer_ack = 1'b0;
    logic          busy;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    bus_sync_tx #(
        .DATAWTH (DW),
        .NUMSTGS (2),
        .TOCYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .xfer_data  (xfer_data),
        .xfer_req   (xfer_req),
        .xfer_ack   (xfer_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic rdy, input logic bsy,
                              input logic req, input logic [DW-1:0] dat);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        check_eq({tag, ".busy"},     32'(busy),     32'(bsy));
        check_eq({tag, ".xfer_req"}, 32'(xfer_req), 32'(req));
        check_eq({tag, ".xfer_data"}, 32'(xfer_data), 32'(dat));
    endtask

    initial begin
        // Reset with ack low
        #12;
        check_port("reset", 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("reset.timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check_port("post_reset", 1'b1, 1'b0, 1'b0, 8'h00);

        // Single transfer: accept at E0, ack toggles after E3, idle after E6
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(1);
        in_valid = 1'b0;
        in_data  = 8'h3C;
        check_port("single.E0", 1'b0, 1'b1, 1'b1, 8'hA5);
        tick(3);
        xfer_ack = 1'b1;
        tick(2);
        check_port("single.E5", 1'b0, 1'b1, 1'b1, 8'hA5);
        tick(1);
        check_port("single.E6", 1'b1, 1'b0, 1'b1, 8'hA5);

        // Back-to-back: second word held off until the first completes
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick(1);
        in_data  = 8'h02;
        check_port("b2b.E0", 1'b0, 1'b1, 1'b0, 8'h01);
        tick(2);
        xfer_ack = 1'b0;
        check_port("b2b.E2", 1'b0, 1'b1, 1'b0, 8'h01);
        tick(2);
        check_port("b2b.E4", 1'b0, 1'b1, 1'b0, 8'h01);
        tick(1);
        check_port("b2b.E5", 1'b1, 1'b0, 1'b0, 8'h01);
        tick(1);
        in_valid = 1'b0;
        check_port("b2b.E6", 1'b0, 1'b1, 1'b1, 8'h02);
        xfer_ack = 1'b1;
        tick(3);
        check_port("b2b.done", 1'b1, 1'b0, 1'b1, 8'h02);

        // Timeout: accept, withhold the ack (ack=1, req goes to 0)
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick(1);
        in_valid = 1'b0;
        check_port("to.E0", 1'b0, 1'b1, 1'b0, 8'h5A);
        tick(7);
        check_eq("to.E7.timeout_err", 32'(timeout_err), 32'd0);
        tick(1);
`ifdef BUS_SYNC_TX_TIMEOUT_EN
        check_eq("to.E8.timeout_err", 32'(timeout_err), 32'd1);
`else
        check_eq("to.E8.timeout_err", 32'(timeout_err), 32'd0);
`endif
        check_eq("to.E8.busy", 32'(busy), 32'd1);
        tick(4);
        check_eq("to.E12.busy", 32'(busy), 32'd1);
        xfer_ack = 1'b0;
        tick(3);
        check_port("to.late_ack", 1'b1, 1'b0, 1'b0, 8'h5A);
`ifdef BUS_SYNC_TX_TIMEOUT_EN
        check_eq("to.sticky", 32'(timeout_err), 32'd1);
`else
        check_eq("to.sticky", 32'(timeout_err), 32'd0);
`endif

        // Reset mid-WAIT acts without a clock edge
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick(1);
        in_valid = 1'b0;
        check_port("midwait.E0", 1'b0, 1'b1, 1'b1, 8'hC3);
        tick(2);
        rst = 1'b1;
        #1;
        check_port("midwait.rst", 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("midwait.timeout_err", 32'(timeout_err), 32'd0);

        // Stale ack: destination still shows 1 when reset releases
        xfer_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check_port("stale.hold", 1'b0, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick(2);
        check_port("stale.ignored", 1'b0, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b0;
        xfer_ack = 1'b0;
        tick(1);
        check_eq("stale.E1.in_ready", 32'(in_ready), 32'd0);
        tick(2);
        check_port("stale.cleared", 1'b1, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
